shared_mem_arbiter: RTL and testbench

Multi-core shared-memory front end that sits directly downstream of the GPU cores (gpu_core_1 instances). It owns the 4096 x 8-bit shared memory and accepts load/store requests from NCORES cores. It grants them one at a time with round-robin priority and returns load data or store completion on the per-core `val_data` strobe. This is the agent that answers each core's `mem_req` / `addr_shared_memory` / `mem_dat_st` and drives its `mem_dat` / `val_data`.

---
 rtl/shared_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_shared_mem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Shared-memory front end: round-robin arbiter over NCORES load/store requesters, owning a 2**ADDR_W x DATA_W memory.
// Latency: request sampled in IDLE -> ACCESS next cycle -> response strobe (val_data_o) one cycle later; 3 cycles minimum per access.
// Backpressure: rtr_i low for the granted core holds RESP with data stable; no other core is granted until that handshake completes.
// Ports: clk_i/reset_i (async active-high); per-core mem_req_i, mem_we_i, packed addr_shared_memory_i / mem_dat_st_i, rtr_i;
//        broadcast mem_dat_o, one-hot val_data_o, grant_id_o (core being served), busy_o (registered, high outside IDLE).
module shared_mem_arbiter #(
  parameter int NCORES = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NCORES-1:0]        mem_req_i,
  input  logic [NCORES-1:0]        mem_we_i,
  input  logic [NCORES*ADDR_W-1:0] addr_shared_memory_i,
  input  logic [NCORES*DATA_W-1:0] mem_dat_st_i,
  input  logic [NCORES-1:0]        rtr_i,
  output logic [DATA_W-1:0]        mem_dat_o,
  output logic [NCORES-1:0]        val_data_o,
  output logic [3:0]               grant_id_o,
  output logic                     busy_o
);

  localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          last_grant_q, last_grant_d;
  logic [3:0]          grant_id_q, grant_id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    gsel;

  assign gsel = grant_id_q[IDX_W-1:0];

  // Round-robin search starting just after the last winner; the first
  // requester found in wrap-around order wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NCORES; i++) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NCORES);
      if (!win_vld && mem_req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdat_d       = wdat_q;
    resp_d       = resp_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d      = ACCESS;
          grant_id_d   = 4'(win_idx);
          last_grant_d = 4'(win_idx);
          we_d         = mem_we_i[win_idx];
          addr_d       = addr_shared_memory_i[win_idx*ADDR_W +: ADDR_W];
          wdat_d       = mem_dat_st_i[win_idx*DATA_W +: DATA_W];
        end
      end
      ACCESS: begin
        state_d = RESP;
        // A store answers with the data it wrote; a load with the array word.
        resp_d  = we_q ? wdat_q : mem_q[addr_q];
      end
      RESP: begin
        if (rtr_i[gsel]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 4'(NCORES - 1);
      grant_id_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
      resp_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      resp_q       <= resp_d;
      busy_q       <= busy_d;
    end
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk_i) begin
    if (state_q == ACCESS && we_q) mem_q[addr_q] <= wdat_q;
  end

  always_comb begin
    val_data_o = '0;
    if (state_q == RESP) val_data_o[gsel] = 1'b1;
  end

  assign mem_dat_o  = resp_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: per-cycle vector table plus a hand-written reset-during-access sequence.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 time unit after the following edge.
// Expected values are hand-computed constants in the table.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_req, mem_we, rtr;
  logic [47:0] addr;
  logic [31:0] dst;
  logic [7:0]  mem_dat;
  logic [3:0]  val_data, grant_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.NCORES(4), .ADDR_W(12), .DATA_W(8)) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .mem_req_i           (mem_req),
    .mem_we_i            (mem_we),
    .addr_shared_memory_i(addr),
    .mem_dat_st_i        (dst),
    .rtr_i               (rtr),
    .mem_dat_o           (mem_dat),
    .val_data_o          (val_data),
    .grant_id_o          (grant_id),
    .busy_o              (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [47:0] addr;
    logic [31:0] dat;
    logic [3:0]  rtr;
    logic [3:0]  e_val;
    logic [3:0]  e_gid;
    logic        e_busy;
    logic        e_chk;
    logic [7:0]  e_dat;
  } vec_t;

  vec_t vecs[$];

  // Per-core packing: core 0 in the low field.
  localparam logic [47:0] AD_S = {12'h000, 12'h000, 12'h000, 12'h012};
  localparam logic [31:0] D_S  = {8'h00, 8'h00, 8'h00, 8'h5A};
  localparam logic [47:0] AD_W = {12'hFFF, 12'h0AB, 12'h0CD, 12'h0EF};
  localparam logic [31:0] D_W  = {8'h07, 8'hEE, 8'hDD, 8'hCC};
  localparam logic [47:0] AD_L = {12'h012, 12'h012, 12'h012, 12'hFFF};
  localparam logic [47:0] AD_C = {12'hFFF, 12'h012, 12'hFFF, 12'h012};
  localparam logic [31:0] D_0  = 32'h0;

  function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] we,
                              input logic [47:0] a, input logic [31:0] d, input logic [3:0] r,
                              input logic [3:0] e_val, input logic [3:0] e_gid, input logic e_busy,
                              input logic e_chk, input logic [7:0] e_dat);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.addr = a; v.dat = d; v.rtr = r;
    v.e_val = e_val; v.e_gid = e_gid; v.e_busy = e_busy; v.e_chk = e_chk; v.e_dat = e_dat;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_req = '0; mem_we = '0; rtr = 4'hF; addr = '0; dst = '0;

    // --- table: each row is applied, one edge elapses, outputs compared ---
    // core 0 store 5A -> 012, then load 012
    add(0, 4'b0001, 4'b0001, AD_S, D_S, 4'hF, 4'b0000, 4'd0, 1, 0, 8'h00);
    add(0, 4'b0001, 4'b0001, AD_S, D_S, 4'hF, 4'b0001, 4'd0, 1, 1, 8'h5A);
    add(0, 4'b0001, 4'b0001, AD_S, D_S, 4'hF, 4'b0000, 4'd0, 0, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, AD_S, D_0, 4'hF, 4'b0000, 4'd0, 1, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, AD_S, D_0, 4'hF, 4'b0001, 4'd0, 1, 1, 8'h5A);
    add(0, 4'b0001, 4'b0000, AD_S, D_0, 4'hF, 4'b0000, 4'd0, 0, 0, 8'h00);
    // core 3 stores 07 -> FFF, core 0 then loads FFF
    add(0, 4'b1000, 4'b1001, AD_W, D_W, 4'hF, 4'b0000, 4'd3, 1, 0, 8'h00);
    add(0, 4'b1000, 4'b1001, AD_W, D_W, 4'hF, 4'b1000, 4'd3, 1, 1, 8'h07);
    add(0, 4'b1000, 4'b1001, AD_W, D_W, 4'hF, 4'b0000, 4'd3, 0, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, AD_L, D_0, 4'hF, 4'b0000, 4'd0, 1, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, AD_L, D_0, 4'hF, 4'b0001, 4'd0, 1, 1, 8'h07);
    add(0, 4'b0000, 4'b0000, AD_L, D_0, 4'hF, 4'b0000, 4'd0, 0, 0, 8'h00);
    // reset clears control state and mem_dat
    add(1, 4'b0000, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd0, 0, 1, 8'h00);
    // contention after reset: all four load together -> 0,1,2,3
    add(0, 4'b1111, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd0, 1, 0, 8'h00);
    add(0, 4'b1111, 4'b0000, AD_C, D_0, 4'hF, 4'b0001, 4'd0, 1, 1, 8'h5A);
    add(0, 4'b1111, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd0, 0, 0, 8'h00);
    add(0, 4'b1110, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd1, 1, 0, 8'h00);
    add(0, 4'b1110, 4'b0000, AD_C, D_0, 4'hF, 4'b0010, 4'd1, 1, 1, 8'h07);
    add(0, 4'b1110, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd1, 0, 0, 8'h00);
    add(0, 4'b1100, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd2, 1, 0, 8'h00);
    add(0, 4'b1100, 4'b0000, AD_C, D_0, 4'hF, 4'b0100, 4'd2, 1, 1, 8'h5A);
    add(0, 4'b1100, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd2, 0, 0, 8'h00);
    add(0, 4'b1000, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd3, 1, 0, 8'h00);
    add(0, 4'b1000, 4'b0000, AD_C, D_0, 4'hF, 4'b1000, 4'd3, 1, 1, 8'h07);
    add(0, 4'b1000, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd3, 0, 0, 8'h00);
    // fairness: core 2 served, then cores 1 and 3 together -> 3 before 1
    add(0, 4'b0100, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd2, 1, 0, 8'h00);
    add(0, 4'b0100, 4'b0000, AD_C, D_0, 4'hF, 4'b0100, 4'd2, 1, 1, 8'h5A);
    add(0, 4'b0100, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd2, 0, 0, 8'h00);
    add(0, 4'b1010, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd3, 1, 0, 8'h00);
    add(0, 4'b1010, 4'b0000, AD_C, D_0, 4'hF, 4'b1000, 4'd3, 1, 1, 8'h07);
    add(0, 4'b1010, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd3, 0, 0, 8'h00);
    add(0, 4'b0010, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd1, 1, 0, 8'h00);
    add(0, 4'b0010, 4'b0000, AD_C, D_0, 4'hF, 4'b0010, 4'd1, 1, 1, 8'h07);
    add(0, 4'b0010, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd1, 0, 0, 8'h00);
    // stall: core 1 load with rtr[1] low (other rtr bits high); core 0 waits
    add(0, 4'b0010, 4'b0000, AD_C, D_0, 4'b1101, 4'b0000, 4'd1, 1, 0, 8'h00);
    add(0, 4'b0010, 4'b0000, AD_C, D_0, 4'b1101, 4'b0010, 4'd1, 1, 1, 8'h07);
    for (int k = 0; k < 5; k++)
      add(0, 4'b0011, 4'b0000, AD_C, D_0, 4'b1101, 4'b0010, 4'd1, 1, 1, 8'h07);
    add(0, 4'b0011, 4'b0000, AD_C, D_0, 4'b1111, 4'b0000, 4'd1, 0, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd0, 1, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, AD_C, D_0, 4'hF, 4'b0001, 4'd0, 1, 1, 8'h5A);
    add(0, 4'b0000, 4'b0000, AD_C, D_0, 4'hF, 4'b0000, 4'd0, 0, 0, 8'h00);

    // --- reset state ---
    step(); step();
    check("rst val_data", 32'(val_data), 32'h0);
    check("rst busy",     32'(busy),     32'h0);
    check("rst grant_id", 32'(grant_id), 32'h0);
    check("rst mem_dat",  32'(mem_dat),  32'h0);

    foreach (vecs[i]) begin
      reset   = vecs[i].rst;
      mem_req = vecs[i].req;
      mem_we  = vecs[i].we;
      addr    = vecs[i].addr;
      dst     = vecs[i].dat;
      rtr     = vecs[i].rtr;
      step();
      check($sformatf("v%0d val_data", i), 32'(val_data), 32'(vecs[i].e_val));
      check($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      check($sformatf("v%0d busy", i),     32'(busy),     32'(vecs[i].e_busy));
      check($sformatf("v%0d onehot", i),   32'($onehot0(val_data)), 32'h1);
      if (vecs[i].e_chk)
        check($sformatf("v%0d mem_dat", i), 32'(mem_dat), 32'(vecs[i].e_dat));
    end

    // --- reset while core 2 store of 33 -> 0FF is in ACCESS ---
    reset = 1'b0; rtr = 4'hF;
    mem_req = 4'b0100; mem_we = 4'b0100;
    addr = {12'h000, 12'h0FF, 12'h000, 12'h000};
    dst  = {8'h00, 8'h33, 8'h00, 8'h00};
    step();
    check("mid access busy",  32'(busy),     32'h1);
    check("mid access grant", 32'(grant_id), 32'h2);
    reset = 1'b1; mem_req = '0; mem_we = '0;
    #1;
    check("async rst val_data", 32'(val_data), 32'h0);
    check("async rst busy",     32'(busy),     32'h0);
    check("async rst grant_id", 32'(grant_id), 32'h0);
    step();
    reset = 1'b0;
    mem_req = 4'b1001;
    addr = {12'h012, 12'h000, 12'h000, 12'h012};
    step();
    check("post rst grant", 32'(grant_id), 32'h0);
    check("post rst busy",  32'(busy),     32'h1);
    step();
    check("post rst val_data", 32'(val_data), 32'h1);
    check("post rst mem_dat",  32'(mem_dat),  32'h5A);
    mem_req = 4'b1000;
    step();
    step();
    check("post rst next grant", 32'(grant_id), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
